// File: rtl/mxc_pkg.sv
// Shared constants and helpers for the multiplexed prescaler bank.
package mxc_pkg;

  // Smallest divide value that produces an output; below this a channel idles.
  localparam int DIV_MIN    = 2;

  // Default widths: the divide value is written as two bus-sized halves.
  localparam int HALF_W_DEF = 16;
  localparam int CNT_W_DEF  = 2 * HALF_W_DEF;

  // Encoding of mxhsel: which half of the divide value a write targets.
  localparam logic HSEL_HI  = 1'b1;
  localparam logic HSEL_LO  = 1'b0;

  // Ceiling log2, used to size channel selects.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/mxc_div_channel.sv
// One prescaler channel: down-counter with glitch-free adoption of a staged
// divide value at terminal count, on sync, or on channel reset.
module mxc_div_channel
  import mxc_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_rst,
  input  logic             en,
  input  logic             sync,
  input  logic [CNT_W-1:0] shadow,
  input  logic             pending,
  output logic             load_ack,
  output logic             clkout,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);

  logic [CNT_W-1:0] active_reg, active_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             clkout_reg, clkout_next;
  logic             tick_reg, tick_next;
  logic             running;

  // Starting count for a divide value; idle values pin the counter at zero.
  function automatic logic [CNT_W-1:0] start_cnt(input logic [CNT_W-1:0] d);
    return (d < DIV_MIN_W) ? '0 : (d - ONE_W);
  endfunction

  // Next-state: channel reset > sync > terminal-count reload > count down.
  always_comb begin
    active_next = active_reg;
    cnt_next    = cnt_reg;
    load_ack    = 1'b0;
    running     = en && (active_reg >= DIV_MIN_W);
    clkout_next = running && (cnt_reg >= (active_reg >> 1));
    tick_next   = running && (cnt_reg == '0);
    if (ch_rst) begin
      active_next = shadow;
      cnt_next    = start_cnt(shadow);
      load_ack    = 1'b1;
      clkout_next = 1'b0;
      tick_next   = 1'b0;
    end else if (sync && en) begin
      active_next = shadow;
      cnt_next    = start_cnt(shadow);
      load_ack    = 1'b1;
    end else if (en && (cnt_reg == '0)) begin
      if (pending) begin
        active_next = shadow;
        cnt_next    = start_cnt(shadow);
        load_ack    = 1'b1;
      end else begin
        cnt_next = start_cnt(active_reg);
      end
    end else if (en) begin
      cnt_next = cnt_reg - ONE_W;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= '0;
      cnt_reg    <= '0;
      clkout_reg <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      active_reg <= active_next;
      cnt_reg    <= cnt_next;
      clkout_reg <= clkout_next;
      tick_reg   <= tick_next;
    end
  end

  assign clkout = clkout_reg;
  assign tick   = tick_reg;

endmodule

// File: rtl/mxc_prescaler_bank.sv
// Bank of multiplexed prescaler channels: bus write qualification, per-channel
// shadow/pending staging, readback mux and the channel instances.
module mxc_prescaler_bank
  import mxc_pkg::*;
#(
  parameter int N_CH   = 8,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int HALF_W = HALF_W_DEF,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   ch_rst,
  input  logic [N_CH-1:0]   ch_en,
  input  logic              sync_in,
  input  logic              wr_sel,
  input  logic              write_int,
  input  logic              dtack,
  input  logic [SEL_W-1:0]  mxsel,
  input  logic              mxhsel,
  input  logic [HALF_W-1:0] wr_data,
  output logic [CNT_W-1:0]  rd_data,
  output logic [N_CH-1:0]   clkout,
  output logic [N_CH-1:0]   tick
);

  logic                         dtack_q_reg;
  logic                         wr_pulse_reg;
  logic [N_CH-1:0][CNT_W-1:0]   shadow_bus;
  logic [N_CH-1:0]              pending_bus;
  logic [N_CH-1:0]              load_ack;

  // One write per dtack rising edge, qualified by address match and write cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dtack_q_reg  <= 1'b0;
      wr_pulse_reg <= 1'b0;
    end else begin
      dtack_q_reg  <= dtack;
      wr_pulse_reg <= wr_sel & write_int & dtack & ~dtack_q_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] shadow_reg;
      logic             pending_reg;
      logic             wr_hit;

      // Out-of-range selects match no channel, so those writes vanish.
      assign wr_hit = wr_pulse_reg && (mxsel == SEL_W'(gi));

      // Shadow staging; a high-half write arms the value for adoption, and
      // wins over a same-cycle load so the new value is not lost.
      always_ff @(posedge clk) begin
        if (rst) begin
          shadow_reg  <= '0;
          pending_reg <= 1'b0;
        end else begin
          if (wr_hit) begin
            if (mxhsel == HSEL_HI) begin
              shadow_reg[CNT_W-1:HALF_W] <= wr_data;
            end else begin
              shadow_reg[HALF_W-1:0] <= wr_data;
            end
          end
          if (wr_hit && (mxhsel == HSEL_HI)) begin
            pending_reg <= 1'b1;
          end else if (load_ack[gi]) begin
            pending_reg <= 1'b0;
          end
        end
      end

      assign shadow_bus[gi]  = shadow_reg;
      assign pending_bus[gi] = pending_reg;

      mxc_div_channel #(
        .CNT_W (CNT_W)
      ) u_ch (
        .clk      (clk),
        .rst      (rst),
        .ch_rst   (ch_rst[gi]),
        .en       (ch_en[gi]),
        .sync     (sync_in),
        .shadow   (shadow_bus[gi]),
        .pending  (pending_bus[gi]),
        .load_ack (load_ack[gi]),
        .clkout   (clkout[gi]),
        .tick     (tick[gi])
      );
    end
  endgenerate

  // Readback of the selected shadow value; unmapped selects read zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (mxsel == SEL_W'(i)) begin
        rd_data = shadow_bus[i];
      end
    end
  end

endmodule

// File: tb/tb_mxc_prescaler_bank.sv
// Scoreboard bench: stimulus queues expected per-cycle values, a monitor on the
// falling edge pops and compares whatever is due on that cycle.
module tb_mxc_prescaler_bank;

  localparam int N_CH = 8;
  localparam int SIG_CLK = 0;
  localparam int SIG_TICK = 1;
  localparam int SIG_RD = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] ch_rst = '0;
  logic [N_CH-1:0] ch_en = '1;
  logic            sync_in = 1'b0;
  logic            wr_sel = 1'b0;
  logic            write_int = 1'b0;
  logic            dtack = 1'b0;
  logic [3:0]      mxsel = '0;
  logic            mxhsel = 1'b0;
  logic [15:0]     wr_data = '0;
  logic [31:0]     rd_data;
  logic [N_CH-1:0] clkout;
  logic [N_CH-1:0] tick;

  typedef struct {
    int          cyc;
    string       name;
    int          sig;
    logic [31:0] mask;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  mxc_prescaler_bank #(
    .N_CH   (N_CH),
    .CNT_W  (32),
    .HALF_W (16),
    .SEL_W  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_rst    (ch_rst),
    .ch_en     (ch_en),
    .sync_in   (sync_in),
    .wr_sel    (wr_sel),
    .write_int (write_int),
    .dtack     (dtack),
    .mxsel     (mxsel),
    .mxhsel    (mxhsel),
    .wr_data   (wr_data),
    .rd_data   (rd_data),
    .clkout    (clkout),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Monitor: compare every entry due on this cycle.
  always @(negedge clk) begin : mon
    exp_t        keep[$];
    logic [31:0] act;
    keep = {};
    foreach (sb_q[i]) begin
      if (sb_q[i].cyc == edge_cnt) begin
        case (sb_q[i].sig)
          SIG_CLK:  act = 32'(clkout);
          SIG_TICK: act = 32'(tick);
          default:  act = rd_data;
        endcase
        act = act & sb_q[i].mask;
        n_cmp = n_cmp + 1;
        if (act != sb_q[i].val) begin
          n_bad = n_bad + 1;
          $display("FAIL %s @cyc %0d: got %h want %h", sb_q[i].name, edge_cnt, act, sb_q[i].val);
        end
      end else if (sb_q[i].cyc < edge_cnt) begin
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL %s @cyc %0d: not sampled, want %h", sb_q[i].name, sb_q[i].cyc, sb_q[i].val);
      end else begin
        keep.push_back(sb_q[i]);
      end
    end
    sb_q = keep;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int cyc, input string name, input int sig,
                      input logic [31:0] mask, input logic [31:0] val);
    exp_t e;
    e.cyc = cyc; e.name = name; e.sig = sig; e.mask = mask; e.val = val;
    sb_q.push_back(e);
  endtask

  // One expectation per character of pat ('1'/'0') for bit ch, starting at cycle start.
  task automatic push_pat(input int start, input string name, input int sig,
                          input int ch, input string pat);
    logic [31:0] m;
    m = 32'(1) << ch;
    for (int k = 0; k < pat.len(); k++) begin
      push(start + k, name, sig, m, (pat[k] == 8'h31) ? m : 32'h0);
    end
  endtask

  task automatic bus_write(input int ch, input logic hi, input logic [15:0] data);
    $display("write ch%0d half=%0d data=%h @cyc %0d", ch, hi, data, edge_cnt);
    wr_sel = 1'b1; write_int = 1'b1; dtack = 1'b1;
    mxsel = 4'(ch); mxhsel = hi; wr_data = data;
    step();
    dtack = 1'b0;
    step();
    wr_sel = 1'b0; write_int = 1'b0;
  endtask

  task automatic program_div(input int ch, input logic [31:0] d);
    bus_write(ch, 1'b0, d[15:0]);
    bus_write(ch, 1'b1, d[31:16]);
  endtask

  initial begin : stim
    int base;
    // Reset state
    repeat (3) step();
    rst = 1'b0;
    push(edge_cnt + 1, "rst_clk", SIG_CLK, 32'hFF, 32'h0);
    push(edge_cnt + 1, "rst_tick", SIG_TICK, 32'hFF, 32'h0);
    push(edge_cnt + 1, "rst_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0);
    step();

    // 1: ch3 D=4
    program_div(3, 32'd4);
    push(edge_cnt + 1, "t1_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0000_0004);
    push_pat(edge_cnt + 2, "t1_clk", SIG_CLK, 3, "11001100");
    push_pat(edge_cnt + 2, "t1_tick", SIG_TICK, 3, "00010001");
    repeat (10) step();

    // 2: ch0 D=5, then restage D=8 mid-period (hi first, lo second)
    program_div(0, 32'd5);
    push_pat(edge_cnt + 2, "t2_clk", SIG_CLK, 0, "11100111001111000011110000");
    push_pat(edge_cnt + 2, "t2_tick", SIG_TICK, 0, "00001000010000000100000001");
    repeat (6) step();
    bus_write(0, 1'b1, 16'h0000);
    bus_write(0, 1'b0, 16'h0008);
    push(edge_cnt + 1, "t2_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0000_0008);
    repeat (18) step();

    // 3: long dtack gives one write; write_int low gives none; bad select ignored
    wr_sel = 1'b1; write_int = 1'b1; dtack = 1'b1;
    mxsel = 4'd1; mxhsel = 1'b0; wr_data = 16'h1234;
    step();
    step();
    wr_data = 16'h5678;
    for (int k = 1; k <= 4; k++) push(edge_cnt + k, "t3_hold_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0000_1234);
    repeat (3) step();
    dtack = 1'b0; wr_sel = 1'b0; write_int = 1'b0;
    step();
    step();
    wr_sel = 1'b1; write_int = 1'b0; dtack = 1'b1; wr_data = 16'h9999;
    step();
    dtack = 1'b0;
    step();
    wr_sel = 1'b0;
    push(edge_cnt + 1, "t3_noint_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0000_1234);
    step();
    bus_write(9, 1'b0, 16'hAAAA);
    push(edge_cnt + 1, "t3_sel9_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0);
    step();
    mxsel = 4'd1;
    push(edge_cnt + 1, "t3_sel1_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0000_1234);
    step();
    bus_write(1, 1'b1, 16'hBEEF);
    push(edge_cnt + 1, "t3_hi_rd", SIG_RD, 32'hFFFF_FFFF, 32'hBEEF_1234);
    step();

    // 5: ch2 D=0, D=1 idle; D=2 toggles every clk
    program_div(2, 32'd0);
    push_pat(edge_cnt + 1, "t5_d0_clk", SIG_CLK, 2, "000000");
    push_pat(edge_cnt + 1, "t5_d0_tick", SIG_TICK, 2, "000000");
    repeat (6) step();
    program_div(2, 32'd1);
    push_pat(edge_cnt + 1, "t5_d1_clk", SIG_CLK, 2, "00000000");
    push_pat(edge_cnt + 1, "t5_d1_tick", SIG_TICK, 2, "00000000");
    repeat (8) step();
    program_div(2, 32'd2);
    push_pat(edge_cnt + 2, "t5_d2_clk", SIG_CLK, 2, "10101010");
    push_pat(edge_cnt + 2, "t5_d2_tick", SIG_TICK, 2, "01010101");
    repeat (10) step();

    // 4: channels 0..7 at D=3..10, ch5 parked mid-count, then sync
    for (int c = 0; c < N_CH; c++) program_div(c, 32'(c + 3));
    repeat (12) step();
    ch_rst = 8'h20;
    push_pat(edge_cnt + 1, "t4_ch5_pre_clk", SIG_CLK, 5, "0110");
    step();
    ch_rst = 8'h00;
    step();
    step();
    ch_en = 8'hDF;
    step();
    sync_in = 1'b1;
    base = edge_cnt;
    push(base + 2, "t4_sync_clk", SIG_CLK, 32'hFF, 32'hDF);
    push(base + 3, "t4_sync_clk", SIG_CLK, 32'hFF, 32'hDF);
    push(base + 4, "t4_sync_clk", SIG_CLK, 32'hFF, 32'hDC);
    push(base + 5, "t4_sync_clk", SIG_CLK, 32'hFF, 32'hD1);
    push(base + 2, "t4_sync_tick", SIG_TICK, 32'hFF, 32'h00);
    push(base + 3, "t4_sync_tick", SIG_TICK, 32'hFF, 32'h00);
    push(base + 4, "t4_sync_tick", SIG_TICK, 32'hFF, 32'h01);
    push(base + 5, "t4_sync_tick", SIG_TICK, 32'hFF, 32'h02);
    push_pat(base + 6, "t4_ch5_resume_clk", SIG_CLK, 5, "110000");
    push_pat(base + 6, "t4_ch5_resume_tick", SIG_TICK, 5, "000001");
    step();
    sync_in = 1'b0;
    repeat (4) step();
    ch_en = 8'hFF;
    repeat (8) step();

    // 6: rst mid-period with ch3 at D=6
    program_div(3, 32'd6);
    repeat (9) step();
    mxsel = 4'd3;
    push(edge_cnt + 1, "t6_pre_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0000_0006);
    step();
    rst = 1'b1;
    push(edge_cnt + 1, "t6_rst_clk", SIG_CLK, 32'hFF, 32'h0);
    push(edge_cnt + 1, "t6_rst_tick", SIG_TICK, 32'hFF, 32'h0);
    push(edge_cnt + 1, "t6_rst_rd", SIG_RD, 32'hFFFF_FFFF, 32'h0);
    step();
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      push(edge_cnt + k, "t6_post_clk", SIG_CLK, 32'hFF, 32'h0);
      push(edge_cnt + k, "t6_post_tick", SIG_TICK, 32'hFF, 32'h0);
    end
    repeat (14) step();

    repeat (3) step();
    foreach (sb_q[i]) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s @cyc %0d: never compared, want %h", sb_q[i].name, sb_q[i].cyc, sb_q[i].val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
